// File: rtl/lc3_reg_file.sv
// LC-3 eight-entry register file: two bypassed read ports, NZP condition codes,
// and a per-register pending scoreboard for stalling on outstanding writes.
module lc3_reg_file #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_reg,
  input  logic [2:0]        dr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ld_cc,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  output logic              n,
  output logic              z,
  output logic              p,
  input  logic              issue_valid,
  input  logic [2:0]        issue_dr,
  output logic [7:0]        pending,
  output logic              sr1_busy,
  output logic              sr2_busy
);

  localparam int unsigned NREGS = 8;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  we;
  logic [NREGS-1:0]  claim;
  logic              byp1;
  logic              byp2;

  // One-hot write enable and scoreboard claim decode
  always_comb begin
    we    = '0;
    claim = '0;
    if (ld_reg)      we    = NREGS'(1) << dr;
    if (issue_valid) claim = NREGS'(1) << issue_dr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (we[i]) regs[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
      z <= 1'b1;
      p <= 1'b0;
    end else if (ld_cc) begin
      n <= wdata[DATA_W-1];
      z <= (wdata == '0);
      p <= ~wdata[DATA_W-1] & (wdata != '0);
    end
  end

  // A new claim outranks a same-cycle write-back to the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= claim | (pending & ~we);
  end

  always_comb begin
    byp1     = ld_reg && (dr == sr1);
    byp2     = ld_reg && (dr == sr2);
    sr1_out  = byp1 ? wdata : regs[sr1];
    sr2_out  = byp2 ? wdata : regs[sr2];
    sr1_busy = pending[sr1] & ~byp1;
    sr2_busy = pending[sr2] & ~byp2;
  end

endmodule

// File: tb/tb_lc3_reg_file.sv
// Scoreboard bench for lc3_reg_file: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lc3_reg_file;

  localparam int SIG_SR1 = 0, SIG_SR2 = 1, SIG_NZP = 2, SIG_PEND = 3, SIG_B1 = 4, SIG_B2 = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_reg, ld_cc, issue_valid;
  logic [2:0]  dr, sr1, sr2, issue_dr;
  logic [15:0] wdata;
  logic [15:0] sr1_out, sr2_out;
  logic        n, z, p, sr1_busy, sr2_busy;
  logic [7:0]  pending;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  lc3_reg_file #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld_reg(ld_reg), .dr(dr), .wdata(wdata),
    .ld_cc(ld_cc), .sr1(sr1), .sr2(sr2), .sr1_out(sr1_out), .sr2_out(sr2_out),
    .n(n), .z(z), .p(p), .issue_valid(issue_valid), .issue_dr(issue_dr),
    .pending(pending), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      SIG_SR1:  return sr1_out;
      SIG_SR2:  return sr2_out;
      SIG_NZP:  return 16'({n, z, p});
      SIG_PEND: return 16'(pending);
      SIG_B1:   return 16'(sr1_busy);
      default:  return 16'(sr2_busy);
    endcase
  endfunction

  // Monitor: pops every expectation due at or before this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = observe(e.sig);
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", e.name, e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_val(input int sig, input logic [15:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_reg = 1'b0; ld_cc = 1'b0; issue_valid = 1'b0;
    dr = 3'd0; issue_dr = 3'd0; wdata = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    sr1 = 3'd0; sr2 = 3'd0;
    #3 rst_n = 1'b0;
    // Activity during reset must be discarded
    ld_reg = 1'b1; dr = 3'd1; wdata = 16'h8005; ld_cc = 1'b1;
    issue_valid = 1'b1; issue_dr = 3'd1;
    step();
    step();
    idle(); sr1 = 3'd1; sr2 = 3'd7;
    expect_val(SIG_SR1, 16'h0000, "rst_sr1");
    expect_val(SIG_SR2, 16'h0000, "rst_sr2");
    expect_val(SIG_NZP, 16'h0002, "rst_nzp");
    expect_val(SIG_PEND, 16'h0000, "rst_pending");
    expect_val(SIG_B1, 16'h0000, "rst_busy1");
    #2 rst_n = 1'b1;

    step(); ld_reg = 1'b1; dr = 3'd3; wdata = 16'h1234;
    step(); dr = 3'd7; wdata = 16'hFFFF;
    step(); idle(); sr1 = 3'd3; sr2 = 3'd7;
    expect_val(SIG_SR1, 16'h1234, "read_r3");
    expect_val(SIG_SR2, 16'hFFFF, "read_r7");

    step(); ld_reg = 1'b1; dr = 3'd5; wdata = 16'hABCD; sr1 = 3'd5; sr2 = 3'd5;
    expect_val(SIG_SR1, 16'hABCD, "bypass_sr1");
    expect_val(SIG_SR2, 16'hABCD, "bypass_sr2");
    step(); idle(); sr2 = 3'd3;
    expect_val(SIG_SR1, 16'hABCD, "r5_after_write");
    expect_val(SIG_SR2, 16'h1234, "r3_unbypassed");

    step(); ld_cc = 1'b1; wdata = 16'h8000;
    expect_val(SIG_NZP, 16'h0002, "nzp_no_bypass");
    step(); wdata = 16'h0000;
    expect_val(SIG_NZP, 16'h0004, "nzp_neg");
    step(); wdata = 16'h0001;
    expect_val(SIG_NZP, 16'h0002, "nzp_zero");
    step(); ld_cc = 1'b0; wdata = 16'h8000;
    expect_val(SIG_NZP, 16'h0001, "nzp_pos");
    step();
    expect_val(SIG_NZP, 16'h0001, "nzp_hold");
    expect_val(SIG_SR1, 16'hABCD, "ldcc_no_regwrite");

    step(); idle(); issue_valid = 1'b1; issue_dr = 3'd2; sr1 = 3'd2;
    expect_val(SIG_PEND, 16'h0000, "pend_latency");
    step(); idle();
    expect_val(SIG_PEND, 16'h0004, "pend_set");
    expect_val(SIG_B1, 16'h0001, "busy_set");
    step(); ld_reg = 1'b1; dr = 3'd2; wdata = 16'h2222;
    expect_val(SIG_B1, 16'h0000, "busy_bypass");
    expect_val(SIG_SR1, 16'h2222, "wb_bypass");
    expect_val(SIG_PEND, 16'h0004, "pend_before_clr");
    step(); idle();
    expect_val(SIG_PEND, 16'h0000, "pend_clr");
    expect_val(SIG_B1, 16'h0000, "busy_clr");

    step(); issue_valid = 1'b1; issue_dr = 3'd4; sr2 = 3'd4;
    step(); ld_reg = 1'b1; dr = 3'd4; wdata = 16'h4444;
    expect_val(SIG_PEND, 16'h0010, "coll_pre");
    expect_val(SIG_B2, 16'h0000, "coll_busy_byp");
    step(); idle();
    expect_val(SIG_PEND, 16'h0010, "coll_set_wins");
    expect_val(SIG_B2, 16'h0001, "coll_busy");
    expect_val(SIG_SR2, 16'h4444, "coll_reg");

    step(); ld_reg = 1'b1; dr = 3'd6; wdata = 16'h1111; sr1 = 3'd6;
    expect_val(SIG_SR1, 16'h1111, "b2b_first");
    step(); wdata = 16'h6666;
    expect_val(SIG_SR1, 16'h6666, "b2b_second");
    step(); ld_reg = 1'b0; wdata = 16'h0000;
    expect_val(SIG_SR1, 16'h6666, "b2b_last_wins");

    // Drop reset between edges with a write, claim and CC update in flight
    step(); ld_reg = 1'b1; dr = 3'd0; wdata = 16'hBEEF; ld_cc = 1'b1;
    issue_valid = 1'b1; issue_dr = 3'd0; sr1 = 3'd6; sr2 = 3'd4;
    #1 rst_n = 1'b0;
    expect_val(SIG_PEND, 16'h0000, "async_pend");
    expect_val(SIG_NZP, 16'h0002, "async_nzp");
    expect_val(SIG_SR1, 16'h0000, "async_r6");
    expect_val(SIG_SR2, 16'h0000, "async_r4");
    step(); idle();
    #2 rst_n = 1'b1;
    step(); sr1 = 3'd0;
    expect_val(SIG_SR1, 16'h0000, "write_lost");
    expect_val(SIG_PEND, 16'h0000, "claim_lost");
    expect_val(SIG_NZP, 16'h0002, "cc_lost");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
